// File: rtl/pattern_matcher.sv
`default_nettype none
// ============================================================================
// pattern_matcher : serial N-bit window compared against P masked patterns
// Revision 1.0
// ============================================================================
module pattern_matcher #(
  parameter int N  = 3,
  parameter int P  = 2,
  parameter int CW = 8
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 i,
  input  logic                                 i_valid,
  input  logic                                 overlap,
  input  logic                                 cfg_we,
  input  logic [((P > 1) ? $clog2(P) : 1)-1:0] cfg_sel,
  input  logic [N-1:0]                         cfg_pat,
  input  logic [N-1:0]                         cfg_mask,
  input  logic                                 clear,
  output logic [P-1:0]                         o,
  output logic                                 any,
  output logic [CW-1:0]                        count
);

  localparam int SW = (P > 1) ? $clog2(P) : 1;
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);
  localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

  typedef enum logic [0:0] {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        window_q, window_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [P-1:0][N-1:0] pat_q, pat_d;
  logic [P-1:0][N-1:0] mask_q, mask_d;
  logic [P-1:0]        o_q, o_d;
  logic                any_q, any_d;
  logic [CW-1:0]       count_q, count_d;

  logic [N-1:0]        win_nxt;
  logic [FW-1:0]       fill_nxt;
  logic [P-1:0]        hit;

  assign win_nxt  = {window_q[N-2:0], i};
  assign fill_nxt = (state_q == ARMED) ? FILL_FULL : fill_q + FW'(1);

  // Hits always use the pattern/mask registers as they were before this edge.
  generate
    for (genvar k = 0; k < P; k++) begin : g_hit
      assign hit[k] = i_valid && (fill_nxt == FILL_FULL) && (|mask_q[k]) &&
                      (((win_nxt ^ pat_q[k]) & mask_q[k]) == '0);
    end
  endgenerate

  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    state_d  = state_q;
    pat_d    = pat_q;
    mask_d   = mask_q;
    o_d      = hit;
    any_d    = |hit;
    count_d  = count_q;

    if (i_valid) begin
      window_d = win_nxt;
      if ((|hit) && !overlap) begin
        fill_d = '0;
      end else begin
        fill_d = fill_nxt;
      end
    end
    state_d = (fill_d == FILL_FULL) ? ARMED : FILLING;

    if (clear) begin
      count_d = '0;
    end else if ((|hit) && (count_q != COUNT_MAX)) begin
      count_d = count_q + CW'(1);
    end

    // Out-of-range selects simply match no slot.
    if (cfg_we) begin
      for (int k = 0; k < P; k++) begin
        if (cfg_sel == SW'(k)) begin
          pat_d[k]  = cfg_pat;
          mask_d[k] = cfg_mask;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FILLING;
      window_q <= '0;
      fill_q   <= '0;
      o_q      <= '0;
      any_q    <= 1'b0;
      count_q  <= '0;
      for (int k = 0; k < P; k++) begin
        pat_q[k]  <= (k == 0) ? {N{1'b1}} : N'(1);
        mask_q[k] <= (k < 2) ? {N{1'b1}} : {N{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      fill_q   <= fill_d;
      pat_q    <= pat_d;
      mask_q   <= mask_d;
      o_q      <= o_d;
      any_q    <= any_d;
      count_q  <= count_d;
    end
  end

  assign o     = o_q;
  assign any   = any_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_matcher.sv
`default_nettype none
// ============================================================================
// tb_pattern_matcher : directed and random checks against a bit-history model
// Revision 1.0
// ============================================================================
module tb_pattern_matcher;
  localparam int N = 3;
  localparam int P = 2;

  logic         clock = 1'b0;
  logic         reset_n, i, i_valid, overlap, cfg_we, clear;
  logic [0:0]   cfg_sel;
  logic [N-1:0] cfg_pat, cfg_mask;
  logic [P-1:0] o, o2;
  logic         any, any2;
  logic [7:0]   count;
  logic [1:0]   count2;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  bit           hist[$];
  int           m_fill;
  int           m_pat[P];
  int           m_mask[P];
  logic [P-1:0] m_o;
  logic         m_any;
  logic [7:0]   m_count;
  logic [1:0]   m_count2;

  pattern_matcher #(.N(N), .P(P), .CW(8)) dut (
    .clock(clock), .reset_n(reset_n), .i(i), .i_valid(i_valid), .overlap(overlap),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
    .clear(clear), .o(o), .any(any), .count(count)
  );

  pattern_matcher #(.N(N), .P(P), .CW(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .i(i), .i_valid(i_valid), .overlap(overlap),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
    .clear(clear), .o(o2), .any(any2), .count(count2)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    hist.delete();
    m_fill = 0;
    for (int k = 0; k < P; k++) begin
      m_pat[k]  = (k == 0) ? (1 << N) - 1 : 1;
      m_mask[k] = (k < 2) ? (1 << N) - 1 : 0;
    end
    m_o = '0; m_any = 1'b0; m_count = '0; m_count2 = '0;
  endtask

  // The last N accepted bits are compared position by position: hist[$] is bit 0.
  task automatic model_edge(input logic v, input logic b, input logic ov, input logic we,
                            input int sel, input int p, input int m, input logic clr);
    logic [P-1:0] h;
    bit ok;
    h = '0;
    if (v) begin
      hist.push_back(b);
      if (hist.size() > N) void'(hist.pop_front());
      if (m_fill < N) m_fill++;
      if (m_fill == N) begin
        for (int k = 0; k < P; k++) begin
          ok = (m_mask[k] != 0);
          for (int j = 0; j < N; j++)
            if (m_mask[k][j] && (hist[hist.size() - 1 - j] != m_pat[k][j])) ok = 0;
          h[k] = ok;
        end
      end
      if (h != 0 && !ov) m_fill = 0;
    end
    m_o = h;
    m_any = |h;
    if (clr) begin
      m_count = 0; m_count2 = 0;
    end else if (h != 0) begin
      if (m_count != 8'hFF) m_count++;
      if (m_count2 != 2'b11) m_count2++;
    end
    if (we && sel < P) begin
      m_pat[sel] = p; m_mask[sel] = m;
    end
  endtask

  task automatic do_edge(input logic v, input logic b, input logic ov, input logic we,
                         input int sel, input int p, input int m, input logic clr);
    i_valid = v; i = b; overlap = ov; cfg_we = we; clear = clr;
    cfg_sel = sel[0:0]; cfg_pat = p[N-1:0]; cfg_mask = m[N-1:0];
    @(posedge clock);
    model_edge(v, b, ov, we, sel, p, m, clr);
    #1;
  endtask

  task automatic bit_in(input logic b, input logic ov);
    do_edge(1'b1, b, ov, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i = 0; i_valid = 0; overlap = 0; cfg_we = 0; clear = 0;
    cfg_sel = '0; cfg_pat = '0; cfg_mask = '0;
    #3;
    model_reset();
    tests_run++;
    if ({o, any, count, o2, any2, count2} !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h want 0000", {o, any, count, o2, any2, count2});
    end
    #9 reset_n = 1'b1;
    do_edge(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    tests_run++;
    if ({o, any, count, o2, any2, count2} !== {m_o, m_any, m_count, m_o, m_any, m_count2}) begin
      tests_failed++;
      $display("FAIL reset_idle: got %h want %h", {o, any, count, o2, any2, count2},
               {m_o, m_any, m_count, m_o, m_any, m_count2});
    end
  endtask

  task automatic test_basic();
    bit seq[10] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 1};
    apply_reset();
    for (int n = 0; n < 10; n++) begin
      bit_in(seq[n], 1'b1);
      tests_run++;
      if ({o, any, count, o2, any2, count2} !== {m_o, m_any, m_count, m_o, m_any, m_count2}) begin
        tests_failed++;
        $display("FAIL basic bit %0d: got %h want %h", n + 1, {o, any, count, o2, any2, count2},
                 {m_o, m_any, m_count, m_o, m_any, m_count2});
      end
    end
    tests_run++;
    if (count !== 8'd3) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d want 3", count);
    end
  endtask

  task automatic test_overlap();
    for (int mode = 1; mode >= 0; mode--) begin
      apply_reset();
      for (int n = 0; n < 5; n++) begin
        bit_in(1'b1, mode[0]);
        tests_run++;
        if ({o, any, count, o2, any2, count2} !== {m_o, m_any, m_count, m_o, m_any, m_count2}) begin
          tests_failed++;
          $display("FAIL overlap%0d bit %0d: got %h want %h", mode, n + 1,
                   {o, any, count, o2, any2, count2}, {m_o, m_any, m_count, m_o, m_any, m_count2});
        end
      end
      tests_run++;
      if (count !== ((mode == 1) ? 8'd3 : 8'd1)) begin
        tests_failed++;
        $display("FAIL overlap%0d_count: got %0d want %0d", mode, count, (mode == 1) ? 3 : 1);
      end
    end
  endtask

  task automatic test_idle();
    apply_reset();
    bit_in(1'b0, 1'b1);
    bit_in(1'b1, 1'b1);
    for (int n = 0; n < 3; n++) do_edge(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    tests_run++;
    if ({o, any} !== 3'b000 || {o, any} !== {m_o, m_any}) begin
      tests_failed++;
      $display("FAIL idle_nohit: got %b want 000", {o, any});
    end
    bit_in(1'b1, 1'b1);
    tests_run++;
    if ({o, any, count} !== {m_o, m_any, m_count} || o !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_011: got o=%b count=%0d want o=00 count=%0d", o, count, m_count);
    end
    bit_in(1'b1, 1'b1);
    tests_run++;
    if (o !== 2'b01 || {o, any, count} !== {m_o, m_any, m_count}) begin
      tests_failed++;
      $display("FAIL idle_fill_full: got o=%b want 01", o);
    end
  endtask

  task automatic test_cfg();
    bit seq[6] = '{1, 0, 1, 1, 1, 1};
    apply_reset();
    do_edge(1'b0, 1'b0, 1'b1, 1'b1, 0, 3'b101, 3'b101, 1'b0);
    for (int n = 0; n < 6; n++) begin
      bit_in(seq[n], 1'b1);
      tests_run++;
      if ({o, any, count, o2, any2, count2} !== {m_o, m_any, m_count, m_o, m_any, m_count2}) begin
        tests_failed++;
        $display("FAIL cfg bit %0d: got %h want %h", n + 1, {o, any, count, o2, any2, count2},
                 {m_o, m_any, m_count, m_o, m_any, m_count2});
      end
    end
    tests_run++;
    if (count !== 8'd3) begin
      tests_failed++;
      $display("FAIL cfg_count: got %0d want 3", count);
    end
    // Mask write coincides with a hit: the old mask still decides this edge.
    do_edge(1'b1, 1'b1, 1'b1, 1'b1, 0, 3'b101, 3'b000, 1'b0);
    tests_run++;
    if (o !== 2'b01 || o !== m_o) begin
      tests_failed++;
      $display("FAIL cfg_same_edge: got o=%b want 01", o);
    end
    for (int n = 0; n < 3; n++) begin
      bit_in(1'b1, 1'b1);
      tests_run++;
      if (o[0] !== 1'b0 || {o, any, count} !== {m_o, m_any, m_count}) begin
        tests_failed++;
        $display("FAIL cfg_mask_zero bit %0d: got o=%b count=%0d want o=00 count=%0d",
                 n + 1, o, count, m_count);
      end
    end
  endtask

  task automatic test_sat();
    apply_reset();
    for (int n = 0; n < 8; n++) bit_in(1'b1, 1'b1);
    tests_run++;
    if (count2 !== 2'd3 || count !== 8'd6 || count2 !== m_count2) begin
      tests_failed++;
      $display("FAIL sat_hold: got count2=%0d count=%0d want 3 and 6", count2, count);
    end
    do_edge(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b1);
    tests_run++;
    if (count2 !== 2'd0 || count !== 8'd0) begin
      tests_failed++;
      $display("FAIL sat_clear: got count2=%0d count=%0d want 0", count2, count);
    end
    do_edge(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
    tests_run++;
    if (count2 !== 2'd0 || count !== 8'd0 || o !== 2'b01 || count !== m_count) begin
      tests_failed++;
      $display("FAIL clear_vs_hit: got count=%0d count2=%0d o=%b want 0 0 01", count, count2, o);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_edge(1'b0, 1'b0, 1'b1, 1'b1, 0, 3'b010, 3'b111, 1'b0);
    bit_in(1'b0, 1'b1);
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b1);
    tests_run++;
    if (o !== 2'b01 || count !== 8'd1) begin
      tests_failed++;
      $display("FAIL pre_reset_hit: got o=%b count=%0d want 01 1", o, count);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({o, any, count, o2, any2, count2} !== 16'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got %h want 0000", {o, any, count, o2, any2, count2});
    end
    model_reset();
    #1 reset_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      bit_in(1'b1, 1'b1);
      tests_run++;
      if (o !== ((n == 2) ? 2'b01 : 2'b00) || {o, any, count} !== {m_o, m_any, m_count}) begin
        tests_failed++;
        $display("FAIL post_reset bit %0d: got o=%b count=%0d want o=%b", n + 1, o, count,
                 (n == 2) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_random();
    logic ov;
    apply_reset();
    ov = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) ov = logic'($urandom_range(0, 1));
      do_edge(logic'($urandom_range(0, 9) < 8), logic'($urandom_range(0, 1)), ov,
              logic'($urandom_range(0, 19) == 0), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              logic'($urandom_range(0, 29) == 0));
      tests_run++;
      if ({o, any, count, o2, any2, count2} !== {m_o, m_any, m_count, m_o, m_any, m_count2}) begin
        tests_failed++;
        $display("FAIL random edge %0d: got %h want %h", n, {o, any, count, o2, any2, count2},
                 {m_o, m_any, m_count, m_o, m_any, m_count2});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_idle();
    test_cfg();
    test_sat();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pattern_matcher.md
PATTERN_MATCHER -- requirements
Module: pattern_matcher

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning window/pattern length in bits (2..8).
REQ-002 The block SHALL have parameter P, default 2, meaning number of independent patterns (1..4).
REQ-003 The block SHALL have parameter CW, default 8, meaning match-counter width.
REQ-004 The block SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port i  input  1  serial data bit.
REQ-007 The block SHALL have port i_valid  input  1  qualifies i on the current edge.
REQ-008 The block SHALL have port overlap  input  1  1 = overlapping matches allowed; 0 = window restarts after a match.
REQ-009 The block SHALL have port cfg_we  input  1  pattern write strobe.
REQ-010 The block SHALL have port cfg_sel  input  max(1,clog2(P))  pattern index to write; indices >= P are ignored.
REQ-011 The block SHALL have port cfg_pat  input  N  pattern value; bit 0 = newest bit.
REQ-012 The block SHALL have port cfg_mask  input  N  compare enable per bit; 0 = don't care.
REQ-013 The block SHALL have port clear  input  1  synchronous clear of count.
REQ-014 The block SHALL have port o  output  P  per-pattern registered match pulse.
REQ-015 The block SHALL have port any  output  1  OR of o, registered.
REQ-016 The block SHALL have port count  output  CW  saturating count of match edges.

Function
REQ-017 The block SHALL keep an N-bit window; on an edge with i_valid=1, the window becomes {window[N-2:0], i}, and fill increments, saturating at N.
REQ-018 The block SHALL implement states FILLING (fill<N) and ARMED (fill==N); FILLING->ARMED when the fill reaches N on a valid edge.
REQ-019 Pattern k SHALL hit on a valid edge iff the next fill==N, mask[k]!=0, and ((next_window ^ pat[k]) & mask[k])==0.
REQ-020 On each edge, o[k] SHALL be loaded with the hit of pattern k, any SHALL be loaded with the OR of all hits, and both SHALL be single-cycle pulses, visible in the cycle right after the edge that sampled the completing bit.
REQ-021 On an edge with i_valid=0, window and fill SHALL hold, and o and any SHALL load 0.
REQ-022 With overlap=1, after a hit, fill SHALL stay N, so consecutive valid bits can each hit.
REQ-023 With overlap=0, on any hit, fill SHALL be set to 0 (->FILLING); the next hit requires N fresh valid bits.
REQ-024 count SHALL increment by 1 per edge with any hit, regardless of how many patterns hit, and SHALL saturate at 2^CW-1.
REQ-025 clear=1 SHALL set count to 0 on that edge, with clear taking priority over a simultaneous hit; window, fill and patterns are unaffected.
REQ-026 cfg_we=1 SHALL write pat[cfg_sel] and mask[cfg_sel] on the edge; a match on the same edge SHALL use the old values.
REQ-027 A pattern whose mask is all-zero SHALL never hit.

Reset
REQ-028 reset_n=0 SHALL immediately, without waiting for a clock edge, force window=0, fill=0 (FILLING), o=0, any=0 and count=0.
REQ-029 Reset SHALL load pat[0]=all ones; pat[k>=1]=1 (binary 0..01); mask[0] and mask[1] all ones; mask[k>=2]=0.
REQ-030 Activity SHALL resume on the first rising edge after reset_n returns high; reset asserted mid-stream SHALL discard partial window contents.

Verification (N=3, P=2 unless stated)
REQ-031 Reset, overlap=1, i_valid=1, bits 1,1,1,0,0,1,1,0,0,1 -> o[0] pulses after bit 3; o[1] pulses after bits 6 and 10; count=3.
REQ-032 Bits 1,1,1,1,1: overlap=1 -> o[0] after bits 3,4,5, count=3; overlap=0 -> o[0] after bit 3 only, count=1.
REQ-033 After reset, bits 0,1 then i_valid=0 for 3 cycles -> no hit, even though a zero-filled window reads 001; then bit 1 -> window 011, no hit; fill==N.
REQ-034 cfg_we with sel=0, pat=101, mask=101, then bits 1,0,1,1,1,1 -> o[0] after bits 3, 5 and 6 (overlap=1); write mask=000 -> o[0] never asserts.
REQ-035 CW=2, five hits -> count=3, held; clear -> 0; clear on the same edge as a hit -> count=0.
REQ-036 reset_n pulsed low between edges mid-stream -> o, any and count drop to 0 before the next edge; patterns return to 111/001; the next two valid bits cannot hit.
